// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// load/store size encodings and the byte-enable width.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_type;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam int BE_WIDTH = 4;

    // Size lives in funct3[1:0]; halfwords need even offsets, words need offset 0.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic result;
        result = 1'b0;
        case (funct3[1:0])
            2'd0:    result = 1'b0;
            2'd1:    result = offset[0];
            default: result = (offset != 2'd0);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load lane selection with sign/zero extension, and misalignment detection.
module load_store_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [BE_WIDTH-1:0]   be,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] lane;

    assign misaligned = is_misaligned(funct3, offset);
    assign lane       = rdata >> {offset, 3'b000};

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'd0: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            F3_LH:   load_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access stage feeding MEM/WB.
// A req/gnt/rvalid bus is driven from the held EX/MEM contents; upstream stalls meanwhile.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_write_data,
    input  logic [2:0]                ex_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_reg_write,
    output logic [DATA_WIDTH-1:0]     from_mem,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output logic                      mem_reg_write,
    output logic                      stall,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [BE_WIDTH-1:0]       dmem_be,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      misaligned
);

    mem_state_type state, state_next;

    logic                  mem_valid;
    logic [DATA_WIDTH-1:0] mem_alu_result;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [2:0]            mem_funct3;
    logic                  mem_mem_read;
    logic                  mem_mem_write;

    logic [BE_WIDTH-1:0]   store_be;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  align_bad;
    logic                  is_mem;
    logic                  mem_op;
    logic                  done;
    logic                  wb_write;
    logic [ADDR_WIDTH-1:0] addr_full;

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (mem_funct3),
        .offset     (mem_alu_result[1:0]),
        .store_data (mem_write_data),
        .rdata      (dmem_rdata),
        .be         (store_be),
        .wdata      (store_wdata),
        .load_data  (load_data),
        .misaligned (align_bad)
    );

    assign is_mem     = mem_valid && (mem_mem_read || mem_mem_write);
    assign mem_op     = is_mem && !align_bad;
    assign misaligned = is_mem && align_bad;
    // The stage frees up in the same cycle the response lands.
    assign done       = mem_op && (state == RESP) && dmem_rvalid;
    assign stall      = mem_op && !done;
    assign wb_write   = (mem_valid && !is_mem) || misaligned || done;

    assign from_mem      = mem_alu_result;
    assign addr_full     = ADDR_WIDTH'(mem_alu_result);
    assign dmem_addr     = {addr_full[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_we       = mem_mem_write && !mem_mem_read;
    assign dmem_be       = mem_mem_read ? {BE_WIDTH{1'b1}} : store_be;
    assign dmem_wdata    = store_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    dmem_req   = 1'b1;
                    state_next = dmem_gnt ? RESP : REQ;
                end
            end
            REQ: begin
                dmem_req = 1'b1;
                if (dmem_gnt) state_next = RESP;
            end
            RESP: begin
                if (dmem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_alu_result <= '0;
            mem_write_data <= '0;
            mem_funct3     <= '0;
            mem_rd         <= '0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_result <= ex_alu_result;
            mem_write_data <= ex_write_data;
            mem_funct3     <= ex_funct3;
            mem_rd         <= ex_rd;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_reg_write  <= ex_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid <= wb_write;
            if (wb_write) begin
                // A dropped misaligned access retires without a register write.
                wb_reg_write <= mem_reg_write && !misaligned;
                wb_rd        <= mem_rd;
                wb_data      <= (mem_mem_read && !misaligned) ? load_data : mem_alu_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, zero-wait and delayed
// loads/stores, lane steering, misaligned drop and reset mid-access.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [31:0] from_mem;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    int checks = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_write_data(ex_write_data), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .from_mem(from_mem), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic ld, input logic st, input logic rw);
        ex_valid      = 1'b1;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_write_data = sdata;
        ex_rd         = rd;
        ex_mem_read   = ld;
        ex_mem_write  = st;
        ex_reg_write  = rw;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_reg_write = 1'b0;
    endtask

    // Zero-wait access: gnt with req, rvalid one cycle later.
    task automatic mem_op(input string tag, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] sdata, input logic [4:0] rd, input logic ld,
                          input logic st, input logic rw, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] rdata, input logic [31:0] exp_wb);
        drive(f3, alu, sdata, rd, ld, st, rw);
        tick();
        idle_ex();
        check({tag, "_req"}, 32'(dmem_req), 32'd1);
        check({tag, "_we"}, 32'(dmem_we), 32'(st && !ld));
        check({tag, "_addr"}, dmem_addr, exp_addr);
        check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
        check({tag, "_stall1"}, 32'(stall), 32'd1);
        if (st && !ld) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1;
        check({tag, "_stall_resp"}, 32'(stall), 32'd0);
        check({tag, "_req_resp"}, 32'(dmem_req), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, "_wb_rw"}, 32'(wb_reg_write), 32'(rw));
        check({tag, "_wb_data"}, wb_data, exp_wb);
        check({tag, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_ex();
        ex_alu_result = '0;
        ex_write_data = '0;
        ex_funct3     = '0;
        ex_rd         = '0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_from_mem", from_mem, 32'd0);

        // ALU op: one-cycle pass-through, no stall
        drive(3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1);
        tick();
        idle_ex();
        check("alu_from_mem", from_mem, 32'h0000_1234);
        check("alu_mem_rd", 32'(mem_rd), 32'd5);
        check("alu_mem_rw", 32'(mem_reg_write), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        tick();
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_rd", 32'(wb_rd), 32'd5);
        check("alu_wb_data", wb_data, 32'h0000_1234);
        tick();
        check("bubble_wb_valid", 32'(wb_valid), 32'd0);

        mem_op("sb", 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 1'b1, 1'b0,
               32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0, 32'h0000_0103);
        mem_op("sh", 3'd1, 32'h0000_0102, 32'h0000_5678, 5'd0, 1'b0, 1'b1, 1'b0,
               32'h0000_0100, 4'b1100, 32'h5678_5678, 32'h0, 32'h0000_0102);
        mem_op("sw", 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0,
               32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0, 32'h0000_0104);
        mem_op("lb", 3'd0, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1,
               32'h0000_0100, 4'b1111, 32'h0, 32'h0080_0000, 32'hFFFF_FF80);
        mem_op("lbu", 3'd4, 32'h0000_0102, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1,
               32'h0000_0100, 4'b1111, 32'h0, 32'h0080_0000, 32'h0000_0080);
        mem_op("lh", 3'd1, 32'h0000_0102, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1,
               32'h0000_0100, 4'b1111, 32'h0, 32'h8001_0000, 32'hFFFF_8001);
        mem_op("lhu", 3'd5, 32'h0000_0100, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1,
               32'h0000_0100, 4'b1111, 32'h0, 32'h1234_9ABC, 32'h0000_9ABC);
        mem_op("ldst", 3'd2, 32'h0000_0500, 32'h5555_5555, 5'd4, 1'b1, 1'b1, 1'b1,
               32'h0000_0500, 4'b1111, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D);

        // LW with gnt after 3 cycles and rvalid 2 cycles after that
        drive(3'd2, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        idle_ex();
        ex_alu_result = 32'h0000_DEAD;
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_req", 32'(dmem_req), 32'd1);
            check("lw_wait_addr", dmem_addr, 32'h0000_0300);
            check("lw_wait_be", 32'(dmem_be), 32'hF);
            check("lw_wait_stall", 32'(stall), 32'd1);
            check("lw_wait_from_mem", from_mem, 32'h0000_0300);
            tick();
        end
        dmem_gnt = 1'b1;
        #1;
        check("lw_gnt_req", 32'(dmem_req), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lw_resp_stall", 32'(stall), 32'd1);
            check("lw_resp_req", 32'(dmem_req), 32'd0);
            check("lw_resp_wb", 32'(wb_valid), 32'd0);
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_BABE;
        #1;
        check("lw_done_stall", 32'(stall), 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        check("lw_wb_valid", 32'(wb_valid), 32'd1);
        check("lw_wb_rd", 32'(wb_rd), 32'd9);
        check("lw_wb_data", wb_data, 32'hCAFE_BABE);

        // Misaligned LH: dropped without request or stall
        drive(3'd1, 32'h0000_0201, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
        tick();
        idle_ex();
        check("mis_req", 32'(dmem_req), 32'd0);
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        check("mis_pulse_end", 32'(misaligned), 32'd0);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_wb_rw", 32'(wb_reg_write), 32'd0);
        check("mis_req_after", 32'(dmem_req), 32'd0);

        // Reset while in RESP, then a stray rvalid
        drive(3'd2, 32'h0000_0400, 32'h1122_3344, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        idle_ex();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        check("rr_stall_resp", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_wb_valid", 32'(wb_valid), 32'd0);
        check("rr_stall", 32'(stall), 32'd0);
        check("rr_req", 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        check("rr_stray_wb", 32'(wb_valid), 32'd0);
        check("rr_stray_stall", 32'(stall), 32'd0);
        check("rr_stray_data", wb_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access stage, directly downstream of the execute stage.
- Captures ALU result, store data and controls from execute, and drives a req/gnt/rvalid data-memory bus.
- Aligns and extends loads, then registers results into MEM/WB.
- Provides the EX/MEM forwarding value back to execute (from_mem) and stalls upstream while an access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath and memory word width
ADDR_WIDTH, 32, byte address width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ex_valid  in  1  execute holds a valid instruction
ex_alu_result  in  DATA_WIDTH  ALU result / effective address
ex_write_data  in  DATA_WIDTH  store data (forwarded rs2)
ex_funct3  in  3  load/store size and sign
ex_rd  in  REG_ADDR_WIDTH  destination register
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_reg_write  in  1  writes rd
from_mem  out  DATA_WIDTH  EX/MEM alu_result for forwarding
mem_rd  out  REG_ADDR_WIDTH  EX/MEM rd for hazard unit
mem_reg_write  out  1  EX/MEM reg_write for hazard unit
stall  out  1  hold upstream stages
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
dmem_be  out  4  byte enables
dmem_wdata  out  DATA_WIDTH  lane-shifted store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response/read data valid
dmem_rdata  in  DATA_WIDTH  read word
wb_valid  out  1  MEM/WB valid
wb_reg_write  out  1  MEM/WB write enable
wb_rd  out  REG_ADDR_WIDTH  MEM/WB destination
wb_data  out  DATA_WIDTH  load data or ALU result
misaligned  out  1  one-cycle pulse: misaligned access dropped

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - EX/MEM and MEM/WB valid = 0; all data and control registers = 0.
  - State = IDLE; dmem_req = 0; stall = 0; misaligned = 0.
- EX/MEM register:
  - Loads ex_* when stall = 0.
  - Holds when stall = 1.
  - from_mem, mem_rd and mem_reg_write are direct register outputs.
- States: IDLE, REQ, RESP.
  - IDLE:
    - EX/MEM holds a valid non-memory op: MEM/WB takes wb_data = alu_result next cycle (1-cycle latency).
    - EX/MEM holds a valid aligned load or store: dmem_req = 1 combinationally.
      - dmem_gnt = 1 the same cycle: go to RESP.
      - Otherwise: go to REQ.
  - REQ: hold dmem_req and all dmem_* outputs stable until dmem_gnt, then go to RESP.
  - RESP: wait for dmem_rvalid, which is also required for stores.
    - On dmem_rvalid: write MEM/WB, go to IDLE.
    - dmem_rvalid is ignored in any other state.
- stall = valid memory op in EX/MEM AND NOT (state = RESP AND dmem_rvalid). The stage is therefore free the cycle the response arrives.
- Zero-wait memory (gnt same cycle as req, rvalid the next cycle) gives a 2-cycle memory op and 1 stall cycle.
- Bubbles: MEM/WB valid = 0 on any cycle it is not written with a completed instruction.
- Addressing:
  - dmem_addr = alu_result with low 2 bits cleared; offset = alu_result[1:0].
- Store data and byte enables:
  - SB: be = 4'b0001 << offset; wdata = byte replicated on all four lanes.
  - SH: be = 4'b0011 << offset; wdata = halfword replicated on both halves.
  - SW: be = 4'b1111.
- Loads:
  - LB/LH: select the addressed lane, sign-extend.
  - LBU/LHU: select the addressed lane, zero-extend.
  - LW: pass the full word.
  - Loads drive be = 4'b1111.
- Misaligned access (halfword with offset[0] = 1, or word with offset != 0):
  - No dmem_req is issued.
  - misaligned pulses for 1 cycle.
  - MEM/WB is written with valid = 1 and reg_write = 0.
  - No stall.
- ex_mem_read and ex_mem_write both set: treated as a load.
- Reset asserted mid-access (REQ or RESP): return to IDLE, drop the access, clear all valids. A later stray dmem_rvalid is ignored.

Decomposition:
- Shared common package holds:
  - mem_state_type enum (IDLE/REQ/RESP).
  - funct3 load/store constants (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
  - Byte-enable width constant.
- One combinational sub-module, load_store_align:
  - Inputs: funct3, offset, store data, read word.
  - Outputs: be, lane-shifted wdata, extended load data, misaligned flag.

Test Plan:
- ALU op with alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall never asserted.
- SB at addr 0x103 with data 0xAB, gnt same cycle, rvalid next cycle -> dmem_addr=0x100, be=4'b1000, wdata=0xABABABAB, stall high exactly 1 cycle.
- LB at 0x102 with rdata=0x0080_0000 -> wb_data=0xFFFF_FF80; LBU at the same address -> wb_data=0x0000_0080.
- LW with gnt delayed 3 cycles and rvalid delayed 2 more -> dmem_* outputs stable throughout REQ, stall held, from_mem unchanged, wb_data=dmem_rdata.
- LH at 0x201 -> no dmem_req, misaligned=1 for 1 cycle, wb_valid=1 with wb_reg_write=0.
- Reset asserted in RESP, followed by a stray rvalid -> state IDLE, wb_valid=0, no MEM/WB write.
